// File: rtl/add_serial_feeder.sv
// add_serial_feeder: operand FIFO plus launch/wait/capture sequencer
// for a multi-cycle bit-serial adder, with a valid/ready result port.
module add_serial_feeder #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 12,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic [7:0]       ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_e;

  pair_t            mem_q [DEPTH];
  pair_t            mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  state_e           state_q, state_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic [7:0]       ops_done_q, ops_done_d;
  logic             push;
  logic             pop;
  logic             cap;
  logic             xfer;

  assign push = in_valid && in_ready_q;
  assign xfer = res_valid_q && res_ready;

  // FIFO storage and pointers; ready is registered off the next count
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = '{a: in_a, b: in_b};
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    in_ready_d = (cnt_d != (AW+1)'(DEPTH));
  end

  // Sequencer: pop, launch, wait out the adder, capture, cool down
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    pop         = 1'b0;
    cap         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          add_a_d = mem_q[rptr_q].a;
          add_b_d = mem_q[rptr_q].b;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wcnt_d  = CW'(LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - CW'(1);
        end else if (!res_valid_q || res_ready) begin
          cap = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (xfer) begin
          cap = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (cap) begin
      state_d = (GAP > 0) ? S_GAP : S_IDLE;
      gcnt_d  = GW'((GAP > 0) ? GAP - 1 : 0);
    end
    if (cap) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_out;
    end else if (xfer) begin
      res_valid_d = 1'b0;
    end
    ops_done_d = ops_done_q + 8'(xfer);
  end

  // State registers; reset drops queued pairs and any pending result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      gcnt_q      <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      ops_done_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      gcnt_q      <= gcnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_en    = (state_q == S_LAUNCH);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_add_serial_feeder.sv
// Bench for add_serial_feeder: vector table, stall/reset sequences,
// and random traffic checked against an in-order queue of sums.
module tb_add_serial_feeder;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LAT = 12;
  localparam int G   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         add_en;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic [7:0]   ops_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         en_t[$];
  int         en_cnt  = 0;
  int         n_push  = 0;
  int         del_cnt = 0;
  int         exp_ops = 0;
  logic       chk255  = 1'b0;
  logic [7:0] mon_s;
  logic [7:0] mon_e;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
  } vec_t;
  vec_t vt[6];

  add_serial_feeder #(
    .WIDTH(W), .DEPTH(D), .LATENCY(LAT), .GAP(G)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_out(add_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: output is only correct LAT cycles after add_en
  int         k_add   = 0;
  logic       run_add = 1'b0;
  logic [7:0] true_sum;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_add <= 1'b0;
      k_add   <= 0;
    end else if (add_en) begin
      run_add <= 1'b1;
      k_add   <= 1;
    end else if (run_add && k_add < 100000) begin
      k_add <= k_add + 1;
    end
  end
  assign true_sum = add_a + add_b;
  assign add_out  = (run_add && k_add >= LAT) ? true_sum : ~true_sum;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: accepted pairs queue their sum; results must match in order
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (in_valid && in_ready) begin
        mon_s = in_a + in_b;
        exp_q.push_back(mon_s);
        n_push++;
      end
      if (add_en) begin
        en_t.push_back(cyc);
        en_cnt++;
      end
      if (res_valid && res_ready) begin
        del_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_result", del_cnt, n_push);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum_order", res_sum, mon_e);
        end
        if (del_cnt == 255) chk255 = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk255) begin
      chk255 = 1'b0;
      check("ops_done_255", ops_done, 255);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    res_ready = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    en_t.delete();
    n_push  = 0;
    del_cnt = 0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    check("push_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (G + 3) step();
  endtask

  task automatic single(input vec_t v);
    int t_push, t_en, n;
    check("vec_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = v.a;
    in_b = v.b;
    t_push = cyc;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!add_en && n < 50) begin
      step();
      n++;
    end
    check("vec_en_lat", cyc - t_push, 2);
    t_en = cyc;
    n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    check("vec_res_lat", cyc - t_en, LAT + 1);
    check("vec_sum", res_sum, v.s);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_ops++;
    check("vec_ops", ops_done, exp_ops);
    repeat (G + 3) step();
  endtask

  int   n, acc, hb, b0, rv, i;
  logic pend;

  initial begin
    vt[0] = '{8'h05, 8'h03, 8'h08};
    vt[1] = '{8'hFF, 8'h01, 8'h00};
    vt[2] = '{8'h80, 8'h80, 8'h00};
    vt[3] = '{8'h7F, 8'h01, 8'h80};
    vt[4] = '{8'h12, 8'h34, 8'h46};
    vt[5] = '{8'hAA, 8'h55, 8'hFF};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (3) step();
    check("rst_ctl", 32'({in_ready, add_en, res_valid}), 0);
    check("rst_add", 32'({add_a, add_b}), 0);
    check("rst_res", 32'({res_sum, ops_done}), 0);
    rst = 1'b1;
    #1;
    check("ready_before_clk", in_ready, 0);
    step();
    check("ready_after_clk", in_ready, 1);

    // table-driven single adds
    for (int v = 0; v < 6; v++) single(vt[v]);
    check("table_ops", ops_done, 6);

    // continuous stream: launches evenly spaced
    do_reset();
    res_ready = 1'b1;
    for (int s = 0; s < 6; s++) push_one(8'($urandom), 8'($urandom));
    drain();
    check("stream_en_cnt", en_t.size(), 6);
    for (int e = 1; e < en_t.size(); e++)
      check("stream_spacing", en_t[e] - en_t[e-1], LAT + G + 2);
    check("stream_ops", ops_done, 6);

    // stalled consumer: HOLD, FIFO fills, release
    res_ready = 1'b0;
    b0 = en_cnt;
    push_one(8'h10, 8'h20);
    push_one(8'hFF, 8'h01);
    n = 0;
    while (!res_valid && n < 60) begin
      step();
      n++;
    end
    check("hold_first", res_sum, 8'h30);
    hb = 0;
    repeat (20) begin
      step();
      if (res_valid !== 1'b1 || res_sum !== 8'h30) hb++;
    end
    check("hold_stable", hb, 0);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 5) begin
        in_valid = 1'b1;
        in_a = 8'(acc * 17);
        in_b = 8'h40;
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    check("fifo_accepted", acc, 4);
    check("fifo_full_ready", in_ready, 0);
    check("hold_en", en_cnt - b0, 2);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("hold_next_valid", res_valid, 1);
    check("hold_next_sum", res_sum, 8'h00);
    check("hold_no_extra_en", en_cnt - b0, 2);
    push_one(8'(4 * 17), 8'h40);
    drain();
    check("hold_ops", ops_done, 13);

    // reset while WAIT with two pairs still queued
    res_ready = 1'b1;
    b0 = en_cnt;
    push_one(8'h01, 8'h02);
    push_one(8'h03, 8'h04);
    push_one(8'h05, 8'h06);
    n = 0;
    while (en_cnt == b0 && n < 40) begin
      step();
      n++;
    end
    check("mid_launch", en_cnt - b0, 1);
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", 32'({in_ready, add_en, res_valid}), 0);
    check("mid_rst_add", 32'({add_a, add_b}), 0);
    check("mid_rst_res", 32'({res_sum, ops_done}), 0);
    exp_q.delete();
    en_t.delete();
    n_push = 0;
    del_cnt = 0;
    step();
    step();
    rst = 1'b1;
    b0 = en_cnt;
    rv = 0;
    repeat (30) begin
      step();
      if (res_valid) rv++;
    end
    check("post_rst_no_en", en_cnt - b0, 0);
    check("post_rst_no_res", rv, 0);
    check("post_rst_ready", in_ready, 1);

    // random traffic, 256 results so ops_done wraps
    i = 0;
    n = 0;
    while (i < 256 && n < 20000) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      pend = in_valid && in_ready;
      step();
      n++;
      if (pend) begin
        i++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("rand_pushed", i, 256);
    drain();
    check("wrap_delivered", del_cnt, 256);
    check("wrap_ops", ops_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
